// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore FSM sequencing MIPS-subset instructions (LW, SW, R-type, ADDI,
//   BEQ, BNE, J) through fetch/decode/execute/memory/writeback over a shared
//   ALU and a single memory port. Memory states stall on mem_ready.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   Opcode[5:0]    IR[31:26], sampled in DECODE (latched for MEMADR/BRANCH)
//   mem_ready      memory port finished its access this cycle
//   IRWE, PCWE     IR write, unconditional PC write
//   Branch/BranchNe conditional PC write on equal / not-equal
//   IorD, DMWE     memory address select, data memory write
//   MtoRFSel, RFDSel, RFWE  register-file write data / dest select / enable
//   ALUSrcA, ALUSrcB, ALUOp ALU operand selects and operation class
//   PCSrc          next-PC source select
//   done, illegal  retire pulse / unsupported-opcode pulse
//   state          current state encoding (debug)
module multicycle_controller #(
   parameter int unsigned ALUOPW = 2,
   parameter bit          EN_BNE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        Opcode,
   input  logic              mem_ready,
   output logic              IRWE,
   output logic              PCWE,
   output logic              Branch,
   output logic              BranchNe,
   output logic              IorD,
   output logic              DMWE,
   output logic              MtoRFSel,
   output logic              RFDSel,
   output logic              RFWE,
   output logic              ALUSrcA,
   output logic [1:0]        ALUSrcB,
   output logic [ALUOPW-1:0] ALUOp,
   output logic [1:0]        PCSrc,
   output logic              done,
   output logic              illegal,
   output logic [3:0]        state
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
      BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t     cur;
   state_t     nxt;
   logic [5:0] op_q;
   logic [1:0] aluop2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur  <= FETCH;
         op_q <= '0;
      end else begin
         cur <= nxt;
         if (cur == DECODE)
            op_q <= Opcode;
      end
   end

   always_comb begin
      nxt      = FETCH;
      IRWE     = 1'b0;
      PCWE     = 1'b0;
      Branch   = 1'b0;
      BranchNe = 1'b0;
      IorD     = 1'b0;
      DMWE     = 1'b0;
      MtoRFSel = 1'b0;
      RFDSel   = 1'b0;
      RFWE     = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      aluop2   = 2'b00;
      PCSrc    = 2'b00;
      done     = 1'b0;
      illegal  = 1'b0;
      case (cur)
         FETCH: begin
            ALUSrcB = 2'b01;
            IRWE    = mem_ready;
            PCWE    = mem_ready;
            nxt     = mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            if (Opcode == OP_LW || Opcode == OP_SW)                 nxt = MEMADR;
            else if (Opcode == OP_R)                                nxt = EXEC;
            else if (Opcode == OP_BEQ || (EN_BNE && Opcode == OP_BNE)) nxt = BRANCH;
            else if (Opcode == OP_ADDI)                             nxt = ADDIEX;
            else if (Opcode == OP_J)                                nxt = JUMP;
            else                                                    illegal = 1'b1;
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            nxt     = (op_q == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            IorD = 1'b1;
            nxt  = mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            MtoRFSel = 1'b1;
            RFWE     = 1'b1;
            done     = 1'b1;
         end
         MEMWR: begin
            IorD = 1'b1;
            DMWE = 1'b1;
            done = mem_ready;
            nxt  = mem_ready ? FETCH : MEMWR;
         end
         EXEC: begin
            ALUSrcA = 1'b1;
            aluop2  = 2'b10;
            nxt     = ALUWB;
         end
         ALUWB: begin
            RFDSel = 1'b1;
            RFWE   = 1'b1;
            done   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA  = 1'b1;
            aluop2   = 2'b01;
            PCSrc    = 2'b01;
            Branch   = (op_q == OP_BEQ);
            BranchNe = (op_q == OP_BNE);
            done     = 1'b1;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            nxt     = ADDIWB;
         end
         ADDIWB: begin
            RFWE = 1'b1;
            done = 1'b1;
         end
         JUMP: begin
            PCSrc = 2'b10;
            PCWE  = 1'b1;
            done  = 1'b1;
         end
         default: nxt = FETCH;
      endcase
      // Reset puts the state in FETCH at once, where IRWE/PCWE would follow
      // mem_ready; every strobe is masked while reset is held.
      if (rst) begin
         IRWE     = 1'b0;
         PCWE     = 1'b0;
         RFWE     = 1'b0;
         DMWE     = 1'b0;
         Branch   = 1'b0;
         BranchNe = 1'b0;
         done     = 1'b0;
         illegal  = 1'b0;
      end
   end

   assign ALUOp = ALUOPW'(aluop2);
   assign state = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       irwe, pcwe, br, brne, iord, dmwe, mtorf, rfd, rfwe, srca;
      logic [1:0] srcb, aluop, pcsrc;
      logic       done, ill;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] Opcode;
   logic       mem_ready;

   logic       a_irwe, a_pcwe, a_br, a_brne, a_iord, a_dmwe, a_mtorf, a_rfd, a_rfwe, a_srca, a_done, a_ill;
   logic [1:0] a_srcb, a_aluop, a_pcsrc;
   logic [3:0] a_state;
   logic       b_irwe, b_pcwe, b_br, b_brne, b_iord, b_dmwe, b_mtorf, b_rfd, b_rfwe, b_srca, b_done, b_ill;
   logic [1:0] b_srcb, b_pcsrc;
   logic [2:0] b_aluop;
   logic [3:0] b_state;
   ctl_t       obs1, obs0;

   int unsigned n_cmp, n_fail;
   int unsigned r_done_at, r_dones, r_ills, r_rfwe, r_dmwe, r_pcwe_nf, r_irwe, r_stalls;
   bit          r_hi;
   int unsigned plan[$];

   always #5 clk = ~clk;

   multicycle_controller dut1 (
      .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
      .IRWE(a_irwe), .PCWE(a_pcwe), .Branch(a_br), .BranchNe(a_brne), .IorD(a_iord),
      .DMWE(a_dmwe), .MtoRFSel(a_mtorf), .RFDSel(a_rfd), .RFWE(a_rfwe), .ALUSrcA(a_srca),
      .ALUSrcB(a_srcb), .ALUOp(a_aluop), .PCSrc(a_pcsrc), .done(a_done), .illegal(a_ill),
      .state(a_state)
   );

   multicycle_controller #(.ALUOPW(3), .EN_BNE(1'b0)) dut0 (
      .clk(clk), .rst(rst), .Opcode(Opcode), .mem_ready(mem_ready),
      .IRWE(b_irwe), .PCWE(b_pcwe), .Branch(b_br), .BranchNe(b_brne), .IorD(b_iord),
      .DMWE(b_dmwe), .MtoRFSel(b_mtorf), .RFDSel(b_rfd), .RFWE(b_rfwe), .ALUSrcA(b_srca),
      .ALUSrcB(b_srcb), .ALUOp(b_aluop), .PCSrc(b_pcsrc), .done(b_done), .illegal(b_ill),
      .state(b_state)
   );

   assign obs1 = {a_state, a_irwe, a_pcwe, a_br, a_brne, a_iord, a_dmwe, a_mtorf, a_rfd,
                  a_rfwe, a_srca, a_srcb, a_aluop, a_pcsrc, a_done, a_ill};
   assign obs0 = {b_state, b_irwe, b_pcwe, b_br, b_brne, b_iord, b_dmwe, b_mtorf, b_rfd,
                  b_rfwe, b_srca, b_srcb, b_aluop[1:0], b_pcsrc, b_done, b_ill};

   // ---------------- reference model ----------------
   function automatic bit legal(input logic [5:0] op, input bit en);
      return (op == 6'd35 || op == 6'd43 || op == 6'd0 || op == 6'd4 ||
              op == 6'd8 || op == 6'd2 || (op == 6'd5 && en));
   endfunction

   function automatic int unsigned lat_of(input logic [5:0] op, input bit en);
      case (op)
         6'd35: return 5;
         6'd43, 6'd0, 6'd8: return 4;
         6'd4, 6'd2: return 3;
         6'd5: return en ? 3 : 2;
         default: return 2;
      endcase
   endfunction

   function automatic void make_plan(input logic [5:0] op, input bit en);
      plan.delete();
      plan.push_back(0);
      plan.push_back(1);
      case (op)
         6'd35: begin plan.push_back(2); plan.push_back(3); plan.push_back(4); end
         6'd43: begin plan.push_back(2); plan.push_back(5); end
         6'd0:  begin plan.push_back(6); plan.push_back(7); end
         6'd4:  plan.push_back(8);
         6'd5:  if (en) plan.push_back(8);
         6'd8:  begin plan.push_back(9); plan.push_back(10); end
         6'd2:  plan.push_back(11);
         default: ;
      endcase
   endfunction

   function automatic ctl_t model_out(input int unsigned st, input logic mr,
                                      input logic [5:0] op, input bit en);
      ctl_t c;
      c = '0;
      c.st = 4'(st);
      case (st)
         0:  begin c.srcb = 2'b01; c.irwe = mr; c.pcwe = mr; end
         1:  begin c.srcb = 2'b11; c.ill = !legal(op, en); end
         2:  begin c.srca = 1'b1; c.srcb = 2'b10; end
         3:  c.iord = 1'b1;
         4:  begin c.mtorf = 1'b1; c.rfwe = 1'b1; c.done = 1'b1; end
         5:  begin c.iord = 1'b1; c.dmwe = 1'b1; c.done = mr; end
         6:  begin c.srca = 1'b1; c.aluop = 2'b10; end
         7:  begin c.rfd = 1'b1; c.rfwe = 1'b1; c.done = 1'b1; end
         8:  begin c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.done = 1'b1;
                   c.br = (op == 6'd4); c.brne = (op == 6'd5); end
         9:  begin c.srca = 1'b1; c.srcb = 2'b10; end
         10: begin c.rfwe = 1'b1; c.done = 1'b1; end
         11: begin c.pcsrc = 2'b10; c.pcwe = 1'b1; c.done = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // Runs one instruction from FETCH, comparing every cycle against the model.
   task automatic run_instr(input string name, input logic [5:0] op, input bit use0,
                            input int unsigned stall_st, input int unsigned stall_n,
                            input int unsigned pct);
      int unsigned idx, cyc, left, st;
      logic mr;
      ctl_t ex, got;
      bit en;
      en = !use0;
      make_plan(op, en);
      Opcode = op;
      left = stall_n; idx = 0; cyc = 0;
      r_done_at = 0; r_dones = 0; r_ills = 0; r_rfwe = 0; r_dmwe = 0;
      r_pcwe_nf = 0; r_irwe = 0; r_stalls = 0; r_hi = 1'b0;
      while (idx < plan.size()) begin
         st = plan[idx];
         if (st == stall_st && left > 0) begin mr = 1'b0; left--; end
         else mr = ($urandom_range(0, 99) >= pct);
         mem_ready = mr;
         cyc++;
         @(negedge clk);
         ex  = model_out(st, mr, op, en);
         got = use0 ? obs0 : obs1;
         n_cmp++;
         if (got !== ex) begin
            n_fail++;
            $display("FAIL %s op=%b cyc=%0d got=%h exp=%h", name, op, cyc, got, ex);
         end
         if ((got.done || got.ill) && r_done_at == 0) r_done_at = cyc;
         if (got.done) r_dones++;
         if (got.ill)  r_ills++;
         if (got.rfwe) r_rfwe++;
         if (got.dmwe) r_dmwe++;
         if (got.irwe) r_irwe++;
         if (got.pcwe && st != 0) r_pcwe_nf++;
         if (use0 && b_aluop[2] !== 1'b0) r_hi = 1'b1;
         if ((st == 0 || st == 3 || st == 5) && !mr) r_stalls++;
         else idx++;
         @(posedge clk); #1;
         if (st == 1) Opcode = 6'($urandom);
         if (cyc > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout got=%0d cycles required<=400", name, cyc);
            break;
         end
      end
      n_cmp++;
      if (r_done_at != lat_of(op, en) + r_stalls) begin
         n_fail++;
         $display("FAIL %s_latency got=%0d exp=%0d", name, r_done_at, lat_of(op, en) + r_stalls);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      ctl_t rz;
      rz = '0; rz.srcb = 2'b01;
      rst = 1'b1; mem_ready = 1'b1; Opcode = 6'd35;
      #3;
      n_cmp++;
      if (obs1 !== rz) begin n_fail++; $display("FAIL reset_dut1 got=%h exp=%h", obs1, rz); end
      n_cmp++;
      if (obs0 !== rz || b_aluop !== 3'b000) begin n_fail++; $display("FAIL reset_dut0 got=%h exp=%h", obs0, rz); end
      @(posedge clk); #1;
      n_cmp++;
      if (obs1 !== rz) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", obs1, rz); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_lw();
      run_instr("lw", 6'd35, 1'b0, 99, 0, 0);
      n_cmp++;
      if (r_dones != 1 || r_rfwe != 1 || r_irwe != 1) begin
         n_fail++;
         $display("FAIL lw_counts got=%0d/%0d/%0d exp=1/1/1", r_dones, r_rfwe, r_irwe);
      end
   endtask

   task automatic test_sw_stall();
      run_instr("sw_stall", 6'd43, 1'b0, 5, 3, 0);
      n_cmp++;
      if (r_dmwe != 4 || r_rfwe != 0 || r_dones != 1) begin
         n_fail++;
         $display("FAIL sw_counts dmwe/rfwe/done got=%0d/%0d/%0d exp=4/0/1", r_dmwe, r_rfwe, r_dones);
      end
   endtask

   task automatic test_fetch_stall();
      run_instr("fetch_stall", 6'd0, 1'b0, 0, 5, 0);
      n_cmp++;
      if (r_irwe != 1 || r_done_at != 9) begin
         n_fail++;
         $display("FAIL fetch_stall irwe/done_at got=%0d/%0d exp=1/9", r_irwe, r_done_at);
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops [5];
      int unsigned total;
      ops = '{6'd0, 6'd8, 6'd4, 6'd5, 6'd2};
      total = 0;
      for (int i = 0; i < 5; i++) begin
         run_instr("b2b", ops[i], 1'b0, 99, 0, 0);
         total += r_done_at;
      end
      n_cmp++;
      if (total != 17) begin n_fail++; $display("FAIL b2b_total got=%0d exp=17", total); end
      do_reset();
   endtask

   task automatic test_illegal();
      do_reset();
      run_instr("illegal_3f", 6'h3f, 1'b0, 99, 0, 0);
      n_cmp++;
      if (r_ills != 1 || r_dones != 0 || r_rfwe + r_dmwe + r_pcwe_nf != 0) begin
         n_fail++;
         $display("FAIL illegal_3f ill/done/we got=%0d/%0d/%0d exp=1/0/0",
                  r_ills, r_dones, r_rfwe + r_dmwe + r_pcwe_nf);
      end
      do_reset();
      run_instr("bne_disabled", 6'd5, 1'b1, 99, 0, 0);
      n_cmp++;
      if (r_ills != 1 || r_rfwe + r_dmwe + r_pcwe_nf != 0) begin
         n_fail++;
         $display("FAIL bne_disabled ill/we got=%0d/%0d exp=1/0", r_ills, r_rfwe + r_dmwe + r_pcwe_nf);
      end
      do_reset();
      run_instr("wide_aluop", 6'd0, 1'b1, 99, 0, 0);
      n_cmp++;
      if (r_hi !== 1'b0) begin n_fail++; $display("FAIL wide_aluop_upper got=%b exp=0", r_hi); end
      do_reset();
   endtask

   task automatic test_async_reset();
      ctl_t rz;
      logic [5:0] op;
      logic [3:0] tgt;
      rz = '0; rz.srcb = 2'b01;
      for (int k = 0; k < 2; k++) begin
         op  = (k == 0) ? 6'd35 : 6'd43;
         tgt = (k == 0) ? 4'd3 : 4'd5;
         Opcode = op; mem_ready = 1'b1;
         repeat (3) begin @(posedge clk); #1; end
         mem_ready = 1'b0;
         @(posedge clk); #2;
         n_cmp++;
         if (a_state !== tgt || a_iord !== 1'b1 || a_dmwe !== (k == 1)) begin
            n_fail++;
            $display("FAIL async_pre%0d state/iord/dmwe got=%0d/%b/%b exp=%0d/1/%0d", k, a_state, a_iord, a_dmwe, tgt, k);
         end
         rst = 1'b1; mem_ready = 1'b1;
         #1;
         n_cmp++;
         if (obs1 !== rz) begin n_fail++; $display("FAIL async_rst%0d got=%h exp=%h", k, obs1, rz); end
         @(posedge clk); #2;
         n_cmp++;
         if (obs1 !== rz) begin n_fail++; $display("FAIL async_hold%0d got=%h exp=%h", k, obs1, rz); end
         rst = 1'b0;
         run_instr("after_async", 6'd0, 1'b0, 99, 0, 0);
      end
   endtask

   task automatic test_random();
      logic [5:0] pool [7];
      logic [5:0] op;
      pool = '{6'd35, 6'd43, 6'd0, 6'd8, 6'd4, 6'd5, 6'd2};
      for (int i = 0; i < 40; i++) begin
         if (i % 4 == 3) op = 6'($urandom_range(0, 63));
         else op = pool[$urandom_range(0, 6)];
         run_instr("random", op, 1'b0, 99, 0, 30);
         n_cmp++;
         if (r_dones + r_ills != 1) begin
            n_fail++;
            $display("FAIL random_retire op=%b got=%0d exp=1", op, r_dones + r_ills);
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b1; mem_ready = 1'b1; Opcode = '0;
      test_reset();
      test_lw();
      test_sw_stall();
      test_fetch_stall();
      test_back_to_back();
      test_illegal();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the MIPS-subset datapath. It is the sequential successor to the single-cycle main decoder. One Moore FSM sequences every instruction through fetch, decode, execute, memory and writeback, sharing one ALU and one memory port. It sits between the instruction register opcode field and the datapath muxes and write enables, and it stalls on a memory-ready handshake.

## Interface
Parameters:
- ALUOPW, default 2: width of ALUOp; upper bits beyond [1:0] are driven 0.
- EN_BNE, default 1: 1 = opcode 6'b000101 (BNE) decoded; 0 = treated as illegal.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Opcode  in  6  instruction register bits [31:26]; sampled in DECODE only.
- mem_ready  in  1  memory port completed the current access this cycle.
- IRWE  out  1  instruction register write enable.
- PCWE  out  1  unconditional PC write enable.
- Branch  out  1  conditional PC write (equal).
- BranchNe  out  1  conditional PC write (not equal).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- DMWE  out  1  data memory write enable.
- MtoRFSel  out  1  register-file write data: 1 = memory data, 0 = ALUOut.
- RFDSel  out  1  destination register: 1 = rd, 0 = rt.
- RFWE  out  1  register-file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2.
- ALUOp  out  ALUOPW  00 = add, 01 = sub, 10 = funct-decode.
- PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- done  out  1  one-cycle pulse in the final state of each retired instruction.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode.
- state  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Encodings 12-15 are unreachable. If ever entered, the FSM goes to FETCH next cycle with all enables 0.
- Every output not listed for a state is 0 (ALUSrcB 00, PCSrc 00).
- FETCH: IorD 0, ALUSrcA 0, ALUSrcB 01, ALUOp 00, PCSrc 00, IRWE = PCWE = mem_ready. Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: ALUSrcA 0, ALUSrcB 11, ALUOp 00. Next state by Opcode:
  - 100011 or 101011 -> MEMADR
  - 000000 -> EXEC
  - 000100 -> BRANCH
  - 000101 -> BRANCH when EN_BNE = 1
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other opcode -> FETCH with illegal = 1
- MEMADR: ALUSrcA 1, ALUSrcB 10, ALUOp 00. Goes to MEMRD for LW, MEMWR for SW. The opcode is latched in DECODE into an internal register, so Opcode changes after DECODE are ignored.
- MEMRD: IorD 1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: RFDSel 0, MtoRFSel 1, RFWE 1, done 1 -> FETCH.
- MEMWR: IorD 1, DMWE 1, held while mem_ready = 0. When mem_ready = 1: done 1 -> FETCH.
- EXEC: ALUSrcA 1, ALUSrcB 00, ALUOp 10 -> ALUWB.
- ALUWB: RFDSel 1, MtoRFSel 0, RFWE 1, done 1 -> FETCH.
- BRANCH: ALUSrcA 1, ALUSrcB 00, ALUOp 01, PCSrc 01, done 1 -> FETCH. Branch = 1 for BEQ; BranchNe = 1 for BNE. Exactly one of the two is asserted.
- ADDIEX: ALUSrcA 1, ALUSrcB 10, ALUOp 00 -> ADDIWB.
- ADDIWB: RFDSel 0, MtoRFSel 0, RFWE 1, done 1 -> FETCH.
- JUMP: PCSrc 10, PCWE 1, done 1 -> FETCH.

## Timing
- Outputs are combinational from state, except that IRWE/PCWE in FETCH and the MEMWR exit are gated by mem_ready. There is no combinational path from Opcode to any write enable.
- Reset, asynchronous: state goes to FETCH and the latched opcode clears to 0 immediately. While rst = 1, IRWE, PCWE, RFWE, DMWE, Branch, BranchNe, done and illegal are forced 0. Other outputs show FETCH values: IorD 0, ALUSrcB 01, ALUOp 0, PCSrc 00, state 0.
- Reset mid-instruction aborts it. No write enable is asserted in the cycle of reset assertion or while reset is held. The first fetch occurs on the first edge after rst deasserts with mem_ready = 1.
- Latencies with mem_ready tied to 1:
  - LW 5 cycles
  - SW 4 cycles
  - R-type 4 cycles
  - ADDI 4 cycles
  - BEQ/BNE 3 cycles
  - J 3 cycles
  - illegal 2 cycles
- Each cycle with mem_ready = 0 in FETCH, MEMRD or MEMWR adds one cycle. mem_ready is ignored in all other states.
- done and illegal are never asserted in the same cycle. Each is asserted for exactly one cycle per instruction.

## Test plan
- Reset, then LW with mem_ready = 1 -> states 0, 1, 2, 3, 4. RFWE = 1 and MtoRFSel = 1 only in state 4. done pulses in cycle 5. IRWE = PCWE = 1 in cycle 1.
- SW with mem_ready low for 3 cycles in MEMWR -> DMWE = 1 and IorD = 1 for 4 consecutive cycles. done only on the cycle mem_ready = 1. RFWE is never 1.
- Back-to-back R-type, ADDI, BEQ, BNE, J -> total 4+4+3+3+3 = 17 cycles. RFDSel = 1 only in ALUWB. Branch/BranchNe are mutually exclusive. PCSrc = 10 only in JUMP.
- Opcode 6'b111111, and 6'b000101 with EN_BNE = 0 -> illegal pulses in DECODE, return to FETCH, no RFWE/DMWE/PCWE in that instruction.
- rst asserted asynchronously mid-MEMRD and mid-MEMWR -> state = 0 before the next clock edge. DMWE and RFWE are 0 immediately. Normal fetch resumes after deassertion.
- Fetch stall: mem_ready = 0 for 5 cycles in FETCH -> IRWE = PCWE = 0 throughout and state holds at 0. Both assert on the first cycle mem_ready = 1.
